// File: rtl/reset_sequencer_if.sv
// Request/status bundle between reset request sources and the reset sequencer.
interface reset_sequencer_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0] req_in;
  logic [NUM_SRC-1:0] req_mask;
  logic               cause_clr;
  logic               rst_out;
  logic               busy;
  logic [NUM_SRC:0]   cause;
  logic [7:0]         event_cnt;

  modport master (
    output req_in, req_mask, cause_clr,
    input  rst_out, busy, cause, event_cnt
  );

  modport slave (
    input  req_in, req_mask, cause_clr,
    output rst_out, busy, cause, event_cnt
  );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-source reset pulse generator: synchronised, maskable requests produce an
// active-low system reset with power-on delay, minimum width, stretching and hold.
module reset_sequencer #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned PULSE_CYCLES = 10,
  parameter int unsigned POR_CYCLES   = 16,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  reset_sequencer_if.slave bus
);

  localparam int unsigned EVT_W = 8;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POR_LD   = CNT_W'(POR_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POR    = 2'd1,
    ASSERT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_last;
  logic [NUM_SRC-1:0] w_req_s, w_edge;
  logic               w_lvl, w_any_edge;
  logic               w_record, w_merge;
  logic [NUM_SRC:0]   r_cause, w_cause_nxt;
  logic [EVT_W-1:0]   r_evt, w_evt_nxt;
  logic               r_rst_out, r_busy;

  // Request synchronisers; Last tracks the synchronised level in every state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_last <= '0;
    end else begin
      r_sync[0] <= bus.req_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_last <= w_req_s;
    end
  end

  assign w_req_s    = r_sync[SYNC_STAGES-1];
  assign w_edge     = w_req_s & ~r_last & ~bus.req_mask;
  assign w_lvl      = |(w_req_s & ~bus.req_mask);
  assign w_any_edge = |w_edge;

  // Next-state, delay counter and cause/event bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_record    = 1'b0;
    w_merge     = 1'b0;
    w_cause_nxt = r_cause;
    w_evt_nxt   = r_evt;

    case (r_state)
      POR: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      IDLE: begin
        if (w_any_edge) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = PULSE_LD;
          w_record    = 1'b1;
        end
      end
      ASSERT: begin
        if (w_any_edge) begin
          w_cnt_nxt = PULSE_LD;
          w_record  = 1'b1;
          w_merge   = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = w_lvl ? HOLD : IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (w_any_edge) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = PULSE_LD;
          w_record    = 1'b1;
          w_merge     = 1'b1;
        end else if (!w_lvl) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = POR;
    endcase

    if (bus.cause_clr) begin
      w_cause_nxt = '0;
      w_evt_nxt   = '0;
    end
    // A recorded edge beats a coincident clear
    if (w_record) begin
      if (bus.cause_clr || !w_merge) w_cause_nxt = {1'b0, w_edge};
      else                           w_cause_nxt = r_cause | {1'b0, w_edge};
      if (bus.cause_clr)             w_evt_nxt = EVT_W'(1);
      else if (r_evt != EVT_MAX)     w_evt_nxt = r_evt + EVT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= POR;
      r_cnt     <= POR_LD;
      r_rst_out <= 1'b0;
      r_busy    <= 1'b1;
      r_cause   <= {1'b1, {NUM_SRC{1'b0}}};
      r_evt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rst_out <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_cause   <= w_cause_nxt;
      r_evt     <= w_evt_nxt;
    end
  end

  assign bus.rst_out   = r_rst_out;
  assign bus.busy      = r_busy;
  assign bus.cause     = r_cause;
  assign bus.event_cnt = r_evt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random traffic, checked every
// cycle against a delay-line / remaining-time model of the reset generator.
module tb_reset_sequencer;

  localparam int unsigned N     = 4;
  localparam int unsigned PULSE = 10;
  localparam int unsigned PORC  = 16;
  localparam int unsigned S     = 2;

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  reset_sequencer_if #(.NUM_SRC(N)) bus ();

  reset_sequencer #(
    .NUM_SRC(N), .PULSE_CYCLES(PULSE), .POR_CYCLES(PORC), .CNT_W(16), .SYNC_STAGES(S)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: requests seen through an S-deep delay line; output low while POR time
  // remains or while a triggered sequence is live (minimum time left or level held).
  logic [N-1:0] m_dl [S];
  logic [N-1:0] m_last;
  int           m_por_rem;
  int           m_rem;
  bit           m_seq;
  logic [N:0]   m_cause;
  int           m_cnt;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [N-1:0] reqs, e;
    bit lv;
    if (!rst_n) begin
      m_valid   = 1'b1;
      m_por_rem = PORC;
      m_seq     = 1'b0;
      m_rem     = 0;
      m_cause   = {1'b1, {N{1'b0}}};
      m_cnt     = 0;
      m_last    = '0;
      for (int i = 0; i < S; i++) m_dl[i] = '0;
    end else begin
      reqs   = m_dl[S-1];
      e      = reqs & ~m_last & ~bus.req_mask;
      lv     = |(reqs & ~bus.req_mask);
      m_last = reqs;
      for (int i = S - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
      m_dl[0] = bus.req_in;
      if (m_por_rem > 0) begin
        m_por_rem--;
        if (bus.cause_clr) begin m_cause = '0; m_cnt = 0; end
      end else if (e != '0) begin
        if (bus.cause_clr) begin
          m_cause = {1'b0, e};
          m_cnt   = 1;
        end else begin
          m_cause = m_seq ? (m_cause | {1'b0, e}) : {1'b0, e};
          if (m_cnt < 255) m_cnt++;
        end
        m_seq = 1'b1;
        m_rem = PULSE;
      end else begin
        if (bus.cause_clr) begin m_cause = '0; m_cnt = 0; end
        if (m_seq) begin
          if (m_rem > 0) m_rem--;
          if (m_rem == 0 && !lv) m_seq = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : compare
    bit exp_low;
    if (m_valid) begin
      exp_low = (m_por_rem > 0) || m_seq;
      chk("rst_out", 32'(bus.rst_out), 32'(!exp_low));
      chk("busy", 32'(bus.busy), 32'(exp_low));
      chk("cause", 32'(bus.cause), 32'(m_cause));
      chk("event_cnt", 32'(bus.event_cnt), 32'(m_cnt[7:0]));
    end
  end

  // Wait for RstOut low, then count consecutive low cycles; optional mid-pulse request
  task automatic meas_low(input int act_at, input logic [N-1:0] act_bits, output int n);
    int guard = 0;
    n = 0;
    while (bus.rst_out !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("low_seen", 32'(bus.rst_out === 1'b0), 32'(1));
    while (bus.rst_out === 1'b0 && n < 500) begin
      if (n == act_at) bus.req_in = bus.req_in | act_bits;
      else if (n == act_at + 1) bus.req_in = bus.req_in & ~act_bits;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int n;
    rst_n         = 1'b0;
    bus.req_in    = '0;
    bus.req_mask  = '0;
    bus.cause_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Power-on sequence
    meas_low(-1, '0, n);
    chk("por_low_len", 32'(n), 32'(16));
    chk("por_cause", 32'(bus.cause), 32'(5'b10000));
    chk("por_busy", 32'(bus.busy), 32'(0));

    // Single isolated pulse
    bus.req_in[1] = 1'b1; @(negedge clk); bus.req_in[1] = 1'b0;
    meas_low(-1, '0, n);
    chk("pulse_len", 32'(n), 32'(10));
    chk("pulse_cause", 32'(bus.cause), 32'(5'b00010));
    chk("pulse_cnt", 32'(bus.event_cnt), 32'(1));

    // Re-trigger stretch
    bus.req_in[0] = 1'b1; @(negedge clk); bus.req_in[0] = 1'b0;
    meas_low(2, 4'b0100, n);
    chk("stretch_len", 32'(n), 32'(15));
    chk("stretch_cause", 32'(bus.cause), 32'(5'b00101));

    // Hold while request high
    bus.req_in[3] = 1'b1;
    fork
      begin repeat (40) @(negedge clk); bus.req_in[3] = 1'b0; end
      meas_low(-1, '0, n);
    join
    chk("hold_len", 32'(n), 32'(40));
    repeat (3) @(negedge clk);
    bus.req_in[3] = 1'b1;
    repeat (25) @(negedge clk);
    chk("hold_before_mask", 32'(bus.rst_out), 32'(0));
    bus.req_mask = 4'b1000;
    @(negedge clk);
    chk("hold_mask_release", 32'(bus.rst_out), 32'(1));
    bus.req_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    bus.req_mask = '0;
    repeat (3) @(negedge clk);

    // Fully masked toggling changes nothing
    bus.req_mask = 4'hF;
    repeat (60) begin bus.req_in = N'($urandom); @(negedge clk); end
    bus.req_in = '0;
    repeat (4) @(negedge clk);
    bus.req_mask = '0;
    repeat (3) @(negedge clk);
    chk("mask_rst_out", 32'(bus.rst_out), 32'(1));
    chk("mask_cause", 32'(bus.cause), 32'(5'b01000));
    chk("mask_cnt", 32'(bus.event_cnt), 32'(5));

    // Event counter saturation
    repeat (300) begin
      bus.req_in[0] = 1'b1; @(negedge clk);
      bus.req_in[0] = 1'b0; @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("sat_cnt", 32'(bus.event_cnt), 32'(255));
    chk("sat_cause", 32'(bus.cause), 32'(5'b00001));
    chk("sat_released", 32'(bus.rst_out), 32'(1));

    // Clear coincident with a new edge, then reset mid-ASSERT
    bus.req_in[2] = 1'b1;
    repeat (2) @(negedge clk);
    bus.cause_clr = 1'b1;
    @(negedge clk);
    bus.cause_clr = 1'b0;
    chk("clr_edge_cause", 32'(bus.cause), 32'(5'b00100));
    chk("clr_edge_cnt", 32'(bus.event_cnt), 32'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", 32'(bus.rst_out), 32'(0));
    chk("rst_mid_busy", 32'(bus.busy), 32'(1));
    chk("rst_mid_cause", 32'(bus.cause), 32'(5'b10000));
    chk("rst_mid_cnt", 32'(bus.event_cnt), 32'(0));
    rst_n = 1'b1;
    bus.req_in = '0;
    repeat (30) @(negedge clk);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) bus.req_in[b] = ~bus.req_in[b];
      if ($urandom_range(31) == 0) bus.req_mask = N'($urandom);
      bus.cause_clr = ($urandom_range(39) == 0);
      rst_n = ($urandom_range(499) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    bus.cause_clr = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
